// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding,
// counter sizing helper and an elaboration-time check on WIDTH/DIGIT.
`ifndef DIGIT_SERIAL_ADDER_PKG_SV
`define DIGIT_SERIAL_ADDER_PKG_SV

// A digit must be at least one bit, no wider than the word, and tile the word exactly.
`define DSA_CHECK_DIGIT(W, D) \
  if (((D) < 1) || ((D) > (W)) || (((W) % (D)) != 0)) begin : g_bad_digit \
    $error("digit_serial_adder: DIGIT must divide WIDTH"); \
  end

package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_e;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry stage, reused once per cycle by the
// serial adder. c_msb is the carry into the top bit, needed for overflow.
module digit_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co    = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, with valid/ready handshakes on both sides.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cntWidth(NDIG);

  `DSA_CHECK_DIGIT(WIDTH, DIGIT)

  serial_state_e    r_state;
  serial_state_e    w_stateNext;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_cMsb;
  logic             w_accept;
  logic             w_lastDigit;
  logic [WIDTH-1:0] w_accNext;

  digit_adder #(.DIGIT(DIGIT)) u_stage (
    .a     (r_a[DIGIT-1:0]),
    .b     (r_b[DIGIT-1:0]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cMsb)
  );

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_lastDigit = (r_state == RUN) && (r_cnt == CW'(NDIG - 1));
  // New digit enters at the MSB end; after NDIG shifts the word is aligned.
  assign w_accNext   = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_stateNext = RUN;
      RUN:     if (w_lastDigit) w_stateNext = DONE;
      DONE:    if (out_ready)   w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so cout=1 means no borrow occurred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_accNext;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_lastDigit) begin
        r_sum  <= w_accNext;
        r_cout <= w_co;
        r_ovf  <= w_cMsb ^ w_co;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: six lanes with different WIDTH/DIGIT sharing
// one clock and reset, directed scenarios plus a randomized regression.
module tb_digit_serial_adder;

  localparam int NINST = 6;

  function automatic int cfgW(input int k);
    case (k)
      0, 1, 2: return 8;
      3:       return 16;
      4:       return 32;
      default: return 12;
    endcase
  endfunction

  function automatic int cfgD(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      3:       return 4;
      4:       return 8;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid  [NINST];
  logic        inReady  [NINST];
  logic [31:0] aIn      [NINST];
  logic [31:0] bIn      [NINST];
  logic        subIn    [NINST];
  logic        cinIn    [NINST];
  logic        outValid [NINST];
  logic        outReady [NINST];
  logic [31:0] sumOut   [NINST];
  logic        coutOut  [NINST];
  logic        ovfOut   [NINST];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int W = cfgW(g);
    localparam int D = cfgD(g);
    logic [W-1:0] sumLoc;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .a         (aIn[g][W-1:0]),
      .b         (bIn[g][W-1:0]),
      .sub       (subIn[g]),
      .cin       (cinIn[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .sum       (sumLoc),
      .cout      (coutOut[g]),
      .ovf       (ovfOut[g])
    );

    assign sumOut[g] = 32'(sumLoc);
  end

  // Integer-arithmetic reference: unsigned result modulo 2^w, carry/no-borrow,
  // and overflow as the signed result falling outside the w-bit range.
  function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic c,
                                   output logic [31:0] es, output logic ec, output logic eo);
    longint mask, half, ua, ub, sa, sb, full, sres;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    if (!s) begin
      full = ua + ub + longint'(c);
      ec   = (full >> w) != 0;
      sres = sa + sb + longint'(c);
    end else begin
      full = ua - ub - longint'(c);
      ec   = (full >= 0);
      sres = sa - sb - longint'(c);
    end
    es = 32'(full & mask);
    eo = (sres >= half) || (sres < -half);
  endfunction

  // Drives one operation on lane k from a negedge and returns what was seen.
  // lat counts cycles with the accept cycle as cycle 0.
  task automatic opDrive(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c, input int gap, input int stall,
                         input bit pokeValid,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output int lat, output bit stableOk, output bit readyAfter,
                         output bit gotValid);
    int e;
    rs = '0; rc = 1'b0; ro = 1'b0; lat = 0;
    stableOk = 1'b1; readyAfter = 1'b0; gotValid = 1'b0;
    repeat (gap) @(negedge clk);
    e = 0;
    while (!inReady[k] && e < 100) begin
      @(negedge clk);
      e++;
    end
    aIn[k] = a; bIn[k] = b; subIn[k] = s; cinIn[k] = c; inValid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid[k] = 1'b0;
    aIn[k] = $urandom; bIn[k] = $urandom;
    subIn[k] = 1'($urandom_range(0, 1)); cinIn[k] = 1'($urandom_range(0, 1));
    e = 0;
    while (!outValid[k] && e < 100) begin
      @(negedge clk);
      e++;
    end
    if (outValid[k]) begin
      gotValid = 1'b1;
      lat = e + 1;
      rs = sumOut[k]; rc = coutOut[k]; ro = ovfOut[k];
      for (int i = 0; i < stall; i++) begin
        inValid[k] = pokeValid ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!outValid[k] || inReady[k] || sumOut[k] !== rs ||
            coutOut[k] !== rc || ovfOut[k] !== ro)
          stableOk = 1'b0;
      end
      inValid[k] = 1'b0;
      outReady[k] = 1'b1;
      @(negedge clk);
      outReady[k] = 1'b0;
      readyAfter = inReady[k] && !outValid[k];
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NINST; k++) begin
      total++;
      if (inReady[k] !== 1'b1 || outValid[k] !== 1'b0 || sumOut[k] !== 32'h0 ||
          coutOut[k] !== 1'b0 || ovfOut[k] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset lane%0d: rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0",
                 k, inReady[k], outValid[k], sumOut[k], coutOut[k], ovfOut[k]);
      end
    end
  endtask

  task automatic test_add();
    logic [31:0] rs; logic rc, ro; int lat; bit st, ra, gv;
    opDrive(0, 32'h5A, 32'h3C, 1'b0, 1'b0, 0, 0, 1'b0, rs, rc, ro, lat, st, ra, gv);
    total++;
    if (!gv || rs !== 32'h96 || rc !== 1'b0 || ro !== 1'b1) begin
      bad++;
      $display("[TB] FAIL add_5A_3C: got vld=%b sum=%h cout=%b ovf=%b, want sum=96 cout=0 ovf=1",
               gv, rs, rc, ro);
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("[TB] FAIL add_latency: got %0d, want 3", lat);
    end
  endtask

  task automatic test_sub();
    logic [31:0] rs; logic rc, ro; int lat; bit st, ra, gv;
    opDrive(0, 32'h10, 32'h20, 1'b1, 1'b0, 0, 0, 1'b0, rs, rc, ro, lat, st, ra, gv);
    total++;
    if (!gv || rs !== 32'hF0 || rc !== 1'b0 || ro !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_10_20: got vld=%b sum=%h cout=%b ovf=%b, want sum=F0 cout=0 ovf=0",
               gv, rs, rc, ro);
    end
    opDrive(0, 32'h80, 32'h01, 1'b1, 1'b0, 0, 0, 1'b0, rs, rc, ro, lat, st, ra, gv);
    total++;
    if (!gv || rs !== 32'h7F || rc !== 1'b1 || ro !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sub_80_01: got vld=%b sum=%h cout=%b ovf=%b, want sum=7F cout=1 ovf=1",
               gv, rs, rc, ro);
    end
  endtask

  task automatic test_hold();
    logic [31:0] rs; logic rc, ro; int lat; bit st, ra, gv;
    opDrive(0, 32'hFF, 32'h01, 1'b0, 1'b1, 0, 5, 1'b1, rs, rc, ro, lat, st, ra, gv);
    total++;
    if (!gv || rs !== 32'h01 || rc !== 1'b1 || ro !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_result: got vld=%b sum=%h cout=%b ovf=%b, want sum=01 cout=1 ovf=0",
               gv, rs, rc, ro);
    end
    total++;
    if (!st) begin
      bad++;
      $display("[TB] FAIL hold_stable: outputs or in_ready moved during stall, want stable");
    end
    total++;
    if (!ra) begin
      bad++;
      $display("[TB] FAIL hold_release: in_ready=%b out_valid=%b after handshake, want 1 0",
               inReady[0], outValid[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rs; logic rc, ro; int lat; bit st, ra, gv;
    aIn[0] = 32'h55; bIn[0] = 32'h11; subIn[0] = 1'b0; cinIn[0] = 1'b0; inValid[0] = 1'b1;
    @(posedge clk);
    #3;
    inValid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || sumOut[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL async_reset: vld=%b rdy=%b sum=%h, want 0 1 0",
               outValid[0], inReady[0], sumOut[0]);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    opDrive(0, 32'h03, 32'h04, 1'b0, 1'b0, 0, 0, 1'b0, rs, rc, ro, lat, st, ra, gv);
    total++;
    if (!gv || rs !== 32'h07 || rc !== 1'b0 || ro !== 1'b0 || lat != 3) begin
      bad++;
      $display("[TB] FAIL post_reset_op: got vld=%b sum=%h cout=%b ovf=%b lat=%0d, want 07 0 0 3",
               gv, rs, rc, ro, lat);
    end
  endtask

  task automatic test_digit_extremes();
    logic [31:0] rs; logic rc, ro; int lat; bit st, ra, gv;
    int wantLat [2] = '{9, 2};
    for (int j = 0; j < 2; j++) begin
      opDrive(j + 1, 32'h7F, 32'h01, 1'b0, 1'b0, 0, 0, 1'b0, rs, rc, ro, lat, st, ra, gv);
      total++;
      if (!gv || rs !== 32'h80 || rc !== 1'b0 || ro !== 1'b1) begin
        bad++;
        $display("[TB] FAIL extreme_lane%0d: got vld=%b sum=%h cout=%b ovf=%b, want 80 0 1",
                 j + 1, gv, rs, rc, ro);
      end
      total++;
      if (lat != wantLat[j]) begin
        bad++;
        $display("[TB] FAIL extreme_latency_lane%0d: got %0d, want %0d", j + 1, lat, wantLat[j]);
      end
    end
  endtask

  task automatic randomRun(input int k, input int nOps);
    logic [31:0] a, b, rs, es; logic s, c, rc, ro, ec, eo;
    int lat, gap, stall, wantLat; bit st, ra, gv;
    wantLat = cfgW(k) / cfgD(k) + 1;
    for (int i = 0; i < nOps; i++) begin
      a = $urandom; b = $urandom;
      s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
      gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      opDrive(k, a, b, s, c, gap, stall, 1'b0, rs, rc, ro, lat, st, ra, gv);
      refModel(cfgW(k), a, b, s, c, es, ec, eo);
      total++;
      if (!gv || rs !== es || rc !== ec || ro !== eo) begin
        bad++;
        $display("[TB] FAIL random_lane%0d op%0d a=%h b=%h sub=%b cin=%b: got %h/%b/%b, want %h/%b/%b",
                 k, i, a, b, s, c, rs, rc, ro, es, ec, eo);
      end
      total++;
      if (lat != wantLat) begin
        bad++;
        $display("[TB] FAIL random_latency_lane%0d op%0d: got %0d, want %0d", k, i, lat, wantLat);
      end
      total++;
      if (!st || !ra) begin
        bad++;
        $display("[TB] FAIL random_stall_lane%0d op%0d: stable=%b readyAfter=%b, want 1 1",
                 k, i, st, ra);
      end
    end
  endtask

  task automatic test_random();
    fork
      randomRun(3, 3334);
      randomRun(4, 3334);
      randomRun(5, 3334);
    join
  endtask

  initial begin
    for (int k = 0; k < NINST; k++) begin
      inValid[k] = 1'b0; outReady[k] = 1'b0;
      aIn[k] = '0; bIn[k] = '0; subIn[k] = 1'b0; cinIn[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_reset_mid_run();
    test_digit_extremes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, using one DIGIT-bit ripple stage reused every cycle.
- Successor to the single-bit full-adder cell: adds width/digit generics, subtract mode, signed-overflow detection and valid/ready handshakes.
- Serves area-constrained datapaths in the adder/multiplier library, e.g. as the accumulation stage of serial multipliers.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 1.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly (1 <= DIGIT <= WIDTH).
- NDIG, WIDTH/DIGIT, derived localparam, not overridable; number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B+cin; 1 = A-B-cin (cin acts as borrow-in)
- cin  input  1  carry-in / borrow-in
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry-out; in sub mode 1 = no borrow
- ovf  output  1  two's-complement overflow

Interface rule (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- FSM states are IDLE, RUN and DONE; reset state is IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only; there is no input-to-output combinational path.
- Reset values: state IDLE, out_valid 0, in_ready 1, sum 0, cout 0, ovf 0, internal shift registers, digit counter and carry 0.
- IDLE: when in_valid && in_ready, capture the following and go to RUN with cnt=0:
  - a into shift register A;
  - sub ? ~b : b into shift register B;
  - carry = sub ? ~cin : cin.
- RUN, each cycle:
  - Add the low DIGIT bits of A, B and carry.
  - Shift the DIGIT-bit result into the MSB end of the accumulator.
  - Shift A and B right by DIGIT; carry <= stage carry-out; cnt++.
  - At cnt==NDIG-1, go to DONE and load sum <= final accumulator, cout <= stage carry-out, ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- DONE: sum/cout/ovf stay stable while out_valid && !out_ready, for any number of cycles. On out_valid && out_ready, go to IDLE.
- Latency: accept edge at cycle 0 -> out_valid high in cycle NDIG+1. Throughput is one operation per NDIG+2 cycles; there is no accept in the same cycle as output handshake.
- sum/cout/ovf hold the last delivered result through IDLE and RUN. They change only on entry to DONE.
- in_valid, a, b, sub and cin are ignored outside IDLE.
- Degenerate DIGIT=WIDTH: NDIG=1, one RUN cycle, latency 2.
- DIGIT=1: pure bit-serial operation, latency WIDTH+1.
- rst_n asserted in any state: immediately returns to reset values and discards any in-flight operation. No result is produced for it.
- Arithmetic: results are modulo 2^WIDTH.
  - ovf for add: sign(a)==sign(b) && sign(sum)!=sign(a).
  - ovf for sub: signed A-B-cin is out of range.

Decomposition:
- Shared package/header: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a WIDTH%DIGIT elaboration check macro. The same encoding is reused by future serial multipliers.
- One sub-module, digit_adder #(DIGIT): combinational DIGIT-bit ripple chain of full-adder cells.
  - Outputs: s[DIGIT-1:0], co, and c_msb (carry into bit DIGIT-1), which feeds the ovf computation.
- Top level contains only the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, DIGIT=4; a=0x5A, b=0x3C, sub=0, cin=0 -> sum=0x96, cout=0, ovf=1; out_valid rises exactly 3 cycles after the accept edge.
- WIDTH=8, DIGIT=4; a=0x10, b=0x20, sub=1, cin=0 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4; a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, cout=1, ovf=0. Hold out_ready=0 for 5 cycles:
  - sum/cout/ovf/out_valid stay stable and in_ready stays 0;
  - a new in_valid during this window is not accepted;
  - after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN (rst_n low for 1 cycle, asynchronous to clk edge) -> out_valid=0, sum=0, in_ready=1 immediately. A subsequent op 0x03+0x04 returns 0x07 with correct latency.
- WIDTH=8, DIGIT=1 and DIGIT=8; a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0. Latency is 9 and 2 cycles respectively.
- Random regression against a reference model across (WIDTH, DIGIT) = (16,4), (32,8), (12,3): 10k ops with random in_valid/out_ready stalls and zero mismatches. Also checks NDIG+1 latency per op and that no output changes while out_valid && !out_ready.
